mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameters SHALL be none; all widths are fixed at 24-bit operands and a 48-bit result.
REQ-003 Clock  in  1  rising-edge clock, shared with the register file.
REQ-004 ResetN  in  1  synchronous active-low reset, sampled on the rising edge of Clock.
REQ-005 Start  in  1  request a new operation; sampled only when the unit is accepting.
REQ-006 Op  in  2  00 MULU, 01 MUL signed, 10 DIVU, 11 DIV signed.
REQ-007 OperandA  in  24  multiplicand or dividend, driven from register-file ReadRS.
REQ-008 OperandB  in  24  multiplier or divisor, driven from register-file ReadRT.
REQ-009 Busy  out  1  high while an operation is in progress.
REQ-010 Done  out  1  one-cycle pulse marking that the results are valid.
REQ-011 ResultHi  out  24  product[47:24] for multiplies, remainder for divides.
REQ-012 ResultLo  out  24  product[23:0] for multiplies, quotient for divides.
REQ-013 DivByZero  out  1  high when the last completed divide had OperandB = 0.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, FIX and DONE.
REQ-015 IDLE and DONE SHALL accept Start.
- Acceptance at rising edge T latches Op, OperandA and OperandB and moves to RUN.
- The iteration counter loads 0 at acceptance.
REQ-016 Start outside IDLE or DONE SHALL be ignored and SHALL not queue.
REQ-017 Operand changes after acceptance SHALL not affect the result.
REQ-018 RUN SHALL last exactly 24 cycles (counter 0..23), with one radix-2 shift-add or restoring shift-subtract step per cycle.
- RUN exits to FIX at edge T+24.
REQ-019 FIX SHALL apply sign correction for signed ops, then move to DONE at edge T+25.
REQ-020 DONE SHALL last one cycle.
- Done = 1 only in DONE.
- DONE returns to IDLE unless Start is accepted in that same cycle.
- Accept-to-Done latency is therefore 25 cycles.
REQ-021 Busy SHALL be 1 in RUN and FIX and 0 in IDLE and DONE.
REQ-022 ResultHi, ResultLo and DivByZero SHALL update only on the edge entering DONE, and SHALL hold until the next entry to DONE.
REQ-023 Signed operations SHALL iterate on magnitudes.
- Product sign is the XOR of the operand signs.
- The quotient truncates toward zero.
- The remainder takes the sign of the dividend.
REQ-024 MUL/MULU SHALL produce the exact 48-bit product with no overflow; signed 0x800000*0x800000 gives 0x400000_000000.
REQ-025 A divide by zero SHALL still take 25 cycles and SHALL give DivByZero = 1, ResultLo = 0xFFFFFF and ResultHi = dividend.
REQ-026 A signed divide 0x800000 / 0xFFFFFF SHALL give ResultLo = 0x800000 and ResultHi = 0x000000 (wrap), with DivByZero = 0.
REQ-027 Any completed multiply, or any divide with a nonzero divisor, SHALL clear DivByZero.

Reset
REQ-028 When ResetN = 0 at an edge, the block SHALL do all of the following:
- go to IDLE;
- clear the counter and internal accumulators;
- drive Busy = 0, Done = 0, ResultHi = 0, ResultLo = 0 and DivByZero = 0.
REQ-029 A reset mid-operation SHALL abort the operation with no Done pulse; Start in the same cycle as reset SHALL be ignored.
REQ-030 The first Start after ResetN returns high SHALL be accepted normally.

Verification
REQ-031 MULU 0xFFFFFF * 0xFFFFFF -> ResultHi = 0xFFFFFE, ResultLo = 0x000001, Done exactly 25 cycles after acceptance, Busy high 24+1 cycles.
REQ-032 MUL 0xFFFFFD (-3) * 0x000005 -> ResultHi = 0xFFFFFF, ResultLo = 0xFFFFF1.
REQ-033 DIV 0xFFFFF9 (-7) / 0x000002 -> ResultLo = 0xFFFFFD, ResultHi = 0xFFFFFF; then DIV 0x800000 / 0xFFFFFF -> ResultLo = 0x800000, ResultHi = 0.
REQ-034 DIVU 0x000064 / 0 -> DivByZero = 1, ResultLo = 0xFFFFFF, ResultHi = 0x000064 after 25 cycles; the following MULU 2*3 -> DivByZero = 0, ResultLo = 6.
REQ-035 Start pulsed at RUN cycle 5 with different operands -> ignored, first result unchanged; operands changed mid-RUN -> no effect.
REQ-036 ResetN low during RUN cycle 10 -> next cycle Busy = 0 and all outputs 0, no Done pulse; then Start MULU 4*5 -> ResultLo = 20 after 25 cycles.
REQ-037 Back-to-back operations: Start held high during DONE -> the second operation is accepted with no idle gap, and its Done follows 25 cycles later.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - 24x24 multiply / 24/24 divide unit, radix-2 iterative, 25-cycle latency
module mul_div_unit (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [23:0] OperandA,
  input  logic [23:0] OperandB,
  output logic        Busy,
  output logic        Done,
  output logic [23:0] ResultHi,
  output logic [23:0] ResultLo,
  output logic        DivByZero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  // hi: partial product upper half / running remainder
  // lo: multiplier bits being consumed / dividend bits shifting out, quotient shifting in
  logic [23:0] hi_q, hi_d;
  logic [23:0] lo_q, lo_d;
  // multiplicand magnitude for multiplies, divisor magnitude for divides
  logic [23:0] opnd_q, opnd_d;
  logic [23:0] res_hi_q, res_hi_d;
  logic [23:0] res_lo_q, res_lo_d;
  logic        dbz_q, dbz_d;

  logic        neg_a, neg_b;
  logic [23:0] mag_a, mag_b;
  logic [24:0] mul_sum;
  logic [24:0] div_shift;
  logic        div_fits;
  logic [23:0] div_diff;
  logic [47:0] prod, prod_neg;

  // Next-state, iteration datapath and sign correction
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;

    // Signed ops work on magnitudes; 0x800000 maps to itself, which is its unsigned magnitude
    neg_a = Op[0] & OperandA[23];
    neg_b = Op[0] & OperandB[23];
    mag_a = neg_a ? (24'd0 - OperandA) : OperandA;
    mag_b = neg_b ? (24'd0 - OperandB) : OperandB;

    // Shift-add: add multiplicand when the current multiplier bit is set, then shift right
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 25'd0);

    // Restoring divide: the remainder always fits in 24 bits, so a 24-bit difference is exact
    div_shift = {hi_q, lo_q[23]};
    div_fits  = div_shift[24] | (div_shift[23:0] >= opnd_q);
    div_diff  = div_shift[23:0] - opnd_q;

    prod     = {hi_q, lo_q};
    prod_neg = 48'd0 - prod;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          state_d  = S_RUN;
          cnt_d    = 5'd0;
          is_div_d = Op[1];
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          hi_d     = 24'd0;
          lo_d     = Op[1] ? mag_a : mag_b;
          opnd_d   = Op[1] ? mag_b : mag_a;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          hi_d = div_fits ? div_diff : div_shift[23:0];
          lo_d = {lo_q[22:0], div_fits};
        end else begin
          hi_d = mul_sum[24:1];
          lo_d = {mul_sum[0], lo_q[23:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          // A zero divisor leaves quotient all ones and remainder = |dividend| naturally
          dbz_d    = (opnd_q == 24'd0);
          res_hi_d = sign_a_q ? (24'd0 - hi_q) : hi_q;
          if (opnd_q == 24'd0) begin
            res_lo_d = 24'hFFFFFF;
          end else begin
            res_lo_d = (sign_a_q ^ sign_b_q) ? (24'd0 - lo_q) : lo_q;
          end
        end else begin
          dbz_d = 1'b0;
          {res_hi_d, res_lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : prod;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= 24'd0;
      lo_q     <= 24'd0;
      opnd_q   <= 24'd0;
      res_hi_q <= 24'd0;
      res_lo_q <= 24'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy      = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done      = (state_q == S_DONE);
  assign ResultHi  = res_hi_q;
  assign ResultLo  = res_lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Start;
  logic [1:0]  Op;
  logic [23:0] OperandA;
  logic [23:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [23:0] ResultHi;
  logic [23:0] ResultLo;
  logic        DivByZero;

  int checks = 0;
  int failures = 0;

  mul_div_unit dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Busy(Busy), .Done(Done),
    .ResultHi(ResultHi), .ResultLo(ResultLo), .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  // Reference: plain integer arithmetic on the architectural meaning of each op
  function automatic void model(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] hi, output logic [23:0] lo, output logic dbz);
    longint x, y, p, q, r;
    dbz = 1'b0;
    if (op[0]) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    if (!op[1]) begin
      p  = x * y;
      hi = p[47:24];
      lo = p[23:0];
    end else if (b == 24'd0) begin
      dbz = 1'b1;
      hi  = a;
      lo  = 24'hFFFFFF;
    end else begin
      q  = x / y;
      r  = x % y;
      hi = r[23:0];
      lo = q[23:0];
    end
  endfunction

  function automatic logic [23:0] pick_operand();
    logic [23:0] v;
    case ($urandom_range(0, 7))
      0: v = 24'd0;
      1: v = 24'h800000;
      2: v = 24'hFFFFFF;
      3: v = 24'd1;
      4: v = 24'(($urandom_range(0, 15)));
      default: v = 24'($urandom);
    endcase
    return v;
  endfunction

  // Issue one op to an accepting unit and wait (bounded) for Done; lat counts edges after accept
  task automatic do_op(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                       output int lat, output int busy_cyc);
    @(negedge Clock);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clock);
    Start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy === 1'b1) busy_cyc++;
      @(negedge Clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Start = 1'b1; Op = 2'b00; OperandA = 24'd7; OperandB = 24'd9;
    repeat (3) @(negedge Clock);
    ResetN = 1'b1; Start = 1'b0;
    @(negedge Clock);
    checks++;
    if ({Busy, Done, ResultHi, ResultLo, DivByZero} !== 51'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b hi=%h lo=%h dbz=%b, required all zero",
               Busy, Done, ResultHi, ResultLo, DivByZero);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [23:0] as  [7] = '{24'hFFFFFF, 24'hFFFFFD, 24'hFFFFF9, 24'h800000, 24'h000064, 24'd2, 24'h800000};
    logic [23:0] bs  [7] = '{24'hFFFFFF, 24'h000005, 24'h000002, 24'hFFFFFF, 24'h000000, 24'd3, 24'h800000};
    logic [23:0] ehi [7] = '{24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000064, 24'd0, 24'h400000};
    logic [23:0] elo [7] = '{24'h000001, 24'hFFFFF1, 24'hFFFFFD, 24'h800000, 24'hFFFFFF, 24'd6, 24'h000000};
    logic        edz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], lat, bc);
      checks++;
      if (lat !== 25 || bc !== 25) begin
        failures++;
        $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d, required 25/25", i, lat, bc);
      end
      checks++;
      if (ResultHi !== ehi[i] || ResultLo !== elo[i] || DivByZero !== edz[i]) begin
        failures++;
        $display("FAIL directed_result[%0d]: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                 i, ResultHi, ResultLo, DivByZero, ehi[i], elo[i], edz[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [23:0] a, b, hi, lo;
    logic        dz;
    int lat, bc;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      model(op, a, b, hi, lo, dz);
      do_op(op, a, b, lat, bc);
      checks++;
      if (lat !== 25 || ResultHi !== hi || ResultLo !== lo || DivByZero !== dz) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dbz=%b, required lat=25 hi=%h lo=%h dbz=%b",
                 i, op, a, b, lat, ResultHi, ResultLo, DivByZero, hi, lo, dz);
      end
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0 || ResultHi !== hi || ResultLo !== lo) begin
        failures++;
        $display("FAIL random_hold[%0d]: done=%b hi=%h lo=%h, required done=0 hi=%h lo=%h",
                 i, Done, ResultHi, ResultLo, hi, lo);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [23:0] hi, lo;
    logic        dz;
    int lat;
    model(2'b11, 24'hFFF000, 24'h000123, hi, lo, dz);
    @(negedge Clock);
    Start = 1'b1; Op = 2'b11; OperandA = 24'hFFF000; OperandB = 24'h000123;
    @(negedge Clock);
    Start = 1'b0;
    lat = 0;
    while (Done !== 1'b1 && lat < 40) begin
      if (lat == 5) begin
        Start = 1'b1; Op = 2'b00; OperandA = 24'h00ABCD; OperandB = 24'h000777;
      end else begin
        Start = 1'b0;
      end
      if (lat > 5) begin
        OperandA = 24'($urandom);
        OperandB = 24'($urandom);
      end
      @(negedge Clock);
      lat++;
    end
    checks++;
    if (lat !== 25 || ResultHi !== hi || ResultLo !== lo || DivByZero !== dz) begin
      failures++;
      $display("FAIL ignore_start: lat=%0d hi=%h lo=%h dbz=%b, required lat=25 hi=%h lo=%h dbz=%b",
               lat, ResultHi, ResultLo, DivByZero, hi, lo, dz);
    end
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL no_queue: busy=%b done=%b, required busy=0 done=0", Busy, Done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    @(negedge Clock);
    Start = 1'b1; Op = 2'b10; OperandA = 24'h123456; OperandB = 24'h000011;
    @(negedge Clock);
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    ResetN = 1'b0; Start = 1'b1;
    @(negedge Clock);
    checks++;
    if ({Busy, Done, ResultHi, ResultLo, DivByZero} !== 51'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b hi=%h lo=%h dbz=%b, required all zero",
               Busy, Done, ResultHi, ResultLo, DivByZero);
    end
    ResetN = 1'b1; Start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (Done === 1'b1 || Busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_mid_abort: activity_cycles=%0d, required 0", seen);
    end
    do_op(2'b00, 24'd4, 24'd5, lat, bc);
    checks++;
    if (lat !== 25 || ResultLo !== 24'd20 || ResultHi !== 24'd0) begin
      failures++;
      $display("FAIL after_reset_mulu: lat=%0d hi=%h lo=%h, required lat=25 hi=000000 lo=000014",
               lat, ResultHi, ResultLo);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] hi1, lo1, hi2, lo2;
    logic        dz1, dz2;
    logic [23:0] a2, b2;
    int lat, bc;
    a2 = 24'($urandom);
    b2 = 24'($urandom_range(1, 4095));
    model(2'b01, 24'hABCDEF, 24'h123456, hi1, lo1, dz1);
    model(2'b11, a2, b2, hi2, lo2, dz2);
    do_op(2'b01, 24'hABCDEF, 24'h123456, lat, bc);
    Start = 1'b1; Op = 2'b11; OperandA = a2; OperandB = b2;
    @(negedge Clock);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0 || ResultHi !== hi1 || ResultLo !== lo1 || DivByZero !== dz1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b hi=%h lo=%h, required busy=1 done=0 hi=%h lo=%h",
               Busy, Done, ResultHi, ResultLo, hi1, lo1);
    end
    lat = 0;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge Clock);
      lat++;
    end
    checks++;
    if (lat !== 25 || ResultHi !== hi2 || ResultLo !== lo2 || DivByZero !== dz2) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d hi=%h lo=%h dbz=%b, required lat=25 hi=%h lo=%h dbz=%b",
               lat, ResultHi, ResultLo, DivByZero, hi2, lo2, dz2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
